// File: rtl/alu_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package alu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word index width; at least one bit so WORDS = 1 still has a legal register.
    function automatic int idx_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/fulladder_32bit.sv
// 32-bit adder with carry-in/carry-out, shared per-word datapath.
module fulladder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    // Plain ripple-style add; synthesis picks the adder architecture.
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};

endmodule

// File: rtl/mp_addsub_ctrl.sv
// Multi-precision add/subtract sequencer: one 32-bit adder reused over WORDS
// cycles with the carry chained word by word.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; operands latched on accept
//   RUN   | one word per cycle through the adder, carry registered
//   DONE  | result/cout/overflow held until the consumer accepts
module mp_addsub_ctrl
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic                    op_sub,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WORD_W*WORDS-1:0] result,
    output logic                    cout,
    output logic                    overflow,
    output logic                    busy
);

    localparam int W    = WORD_W * WORDS;
    localparam int IW   = idx_w(WORDS);
    localparam int LAST = WORDS - 1;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [WORD_W-1:0] a_word;
    logic [WORD_W-1:0] b_word;
    logic [WORD_W-1:0] sum_word;
    logic              add_cout;

    assign a_word = a_q[int'(idx_q)*WORD_W +: WORD_W];
    assign b_word = b_q[int'(idx_q)*WORD_W +: WORD_W];

    fulladder_32bit u_add (
        .a_i   (a_word),
        .b_i   (b_word),
        .cin_i (carry_q),
        .sum_o (sum_word),
        .cout_o(add_cout)
    );

    // State and datapath registers; reset clears everything so no partial result leaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; subtract is A + ~B with the +1 as initial carry.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub;
                    idx_d   = '0;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[int'(idx_q)*WORD_W +: WORD_W] = sum_word;
                carry_d = add_cout;
                if (int'(idx_q) == LAST) begin
                    cout_d  = add_cout;
                    ovf_d   = (a_word[WORD_W-1] == b_word[WORD_W-1]) &&
                              (sum_word[WORD_W-1] != a_word[WORD_W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = res_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_mp_addsub_ctrl.sv
module tb_mp_addsub_ctrl;

    logic clk;
    logic rst_n;

    // WORDS = 4 instance
    logic         sv4, sr4, op4, rv4, rr4, co4, ov4, bz4;
    logic [127:0] a4, b4, res4;
    // WORDS = 1 instance
    logic         sv1, sr1, op1, rv1, rr1, co1, ov1, bz1;
    logic [31:0]  a1, b1, res1;

    int n_chk  = 0;
    int n_fail = 0;

    mp_addsub_ctrl #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv4), .start_ready(sr4), .op_sub(op4), .a(a4), .b(b4),
        .res_valid(rv4), .res_ready(rr4), .result(res4), .cout(co4),
        .overflow(ov4), .busy(bz4)
    );

    mp_addsub_ctrl #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv1), .start_ready(sr1), .op_sub(op1), .a(a1), .b(b1),
        .res_valid(rv1), .res_ready(rr1), .result(res1), .cout(co1),
        .overflow(ov1), .busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request on the 4-word DUT; returns cycles from accept to res_valid.
    task automatic run4(input logic op, input logic [127:0] a, input logic [127:0] b, output int lat);
        sv4 = 1'b1; op4 = op; a4 = a; b4 = b;
        @(posedge clk); #1;
        sv4 = 1'b0; op4 = ~op; a4 = ~a; b4 = ~b;
        lat = 0;
        while (!rv4 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release4();
        rr4 = 1'b1;
        @(posedge clk); #1;
        rr4 = 1'b0;
        chk("w4 start_ready after accept", 128'(sr4), 128'(1'b1));
        chk("w4 busy after accept", 128'(bz4), 128'(1'b0));
    endtask

    task automatic run1(input logic op, input logic [31:0] a, input logic [31:0] b, output int lat);
        sv1 = 1'b1; op1 = op; a1 = a; b1 = b;
        @(posedge clk); #1;
        sv1 = 1'b0; op1 = ~op; a1 = ~a; b1 = ~b;
        lat = 0;
        while (!rv1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release1();
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        chk("w1 start_ready after accept", 128'(sr1), 128'(1'b1));
    endtask

    task automatic chk_reset4(input string tag);
        chk({tag, " w4 result"},      res4,          128'd0);
        chk({tag, " w4 cout"},        128'(co4),     128'd0);
        chk({tag, " w4 overflow"},    128'(ov4),     128'd0);
        chk({tag, " w4 res_valid"},   128'(rv4),     128'd0);
        chk({tag, " w4 busy"},        128'(bz4),     128'd0);
        chk({tag, " w4 start_ready"}, 128'(sr4),     128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int           lat;
        logic [127:0] ones;
        logic [127:0] held;

        ones = {128{1'b1}};
        sv4 = 0; op4 = 0; a4 = '0; b4 = '0; rr4 = 0;
        sv1 = 0; op1 = 0; a1 = '0; b1 = '0; rr1 = 0;
        rst_n = 1'b0;

        //                op    a                          b              result                     co ov
        vecs[0] = '{1'b0, 128'hFFFF_FFFF,               128'h1,       128'h1_0000_0000,          1'b0, 1'b0};
        vecs[1] = '{1'b0, ones,                          128'h1,       128'h0,                    1'b1, 1'b0};
        vecs[2] = '{1'b1, 128'h5,                        128'h7,       {{127{1'b1}}, 1'b0},       1'b0, 1'b0};
        vecs[3] = '{1'b1, 128'h7,                        128'h5,       128'h2,                    1'b1, 1'b0};
        vecs[4] = '{1'b0, {1'b0, {127{1'b1}}},           128'h1,       {1'b1, 127'd0},            1'b0, 1'b1};
        vecs[5] = '{1'b1, {1'b1, 127'd0},                128'h1,       {1'b0, {127{1'b1}}},       1'b1, 1'b1};
        vecs[6] = '{1'b0, 128'h3,                        128'h4,       128'h7,                    1'b0, 1'b0};
        vecs[7] = '{1'b0, {1'b1, 127'd0},                {1'b1, 127'd0}, 128'h0,                  1'b1, 1'b1};
        vecs[8] = '{1'b1, 128'h1234_5678_9ABC,           128'h1234_5678_9ABC, 128'h0,             1'b1, 1'b0};
        vecs[9] = '{1'b1, 128'h0,                        128'h1,       ones,                      1'b0, 1'b0};

        #1;
        chk_reset4("in reset");
        chk("in reset w1 start_ready", 128'(sr1), 128'd1);
        chk("in reset w1 result", 128'(res1), 128'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset4("after reset");

        // Table-driven vectors on the 4-word instance
        for (int i = 0; i < 10; i++) begin
            run4(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d latency", i),  128'(lat), 128'd4);
            chk($sformatf("v%0d result", i),   res4, vecs[i].res);
            chk($sformatf("v%0d cout", i),     128'(co4), 128'(vecs[i].co));
            chk($sformatf("v%0d overflow", i), 128'(ov4), 128'(vecs[i].ov));
            release4();
        end

        // Backpressure: held result, no new accept while DONE
        run4(1'b1, 128'h7, 128'h5, lat);
        chk("bp latency", 128'(lat), 128'd4);
        held = res4;
        chk("bp result", held, 128'h2);
        for (int k = 0; k < 10; k++) begin
            sv4 = 1'b1; op4 = k[0];
            a4 = {$urandom, $urandom, $urandom, $urandom};
            b4 = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk($sformatf("bp%0d result", k),      res4, 128'h2);
            chk($sformatf("bp%0d cout", k),        128'(co4), 128'd1);
            chk($sformatf("bp%0d overflow", k),    128'(ov4), 128'd0);
            chk($sformatf("bp%0d start_ready", k), 128'(sr4), 128'd0);
            chk($sformatf("bp%0d res_valid", k),   128'(rv4), 128'd1);
        end
        sv4 = 1'b0;
        release4();
        @(posedge clk); #1;
        chk("bp stays idle", 128'(bz4), 128'd0);

        // Stray res_ready in IDLE has no effect
        rr4 = 1'b1;
        @(posedge clk); #1;
        rr4 = 1'b0;
        chk("stray res_ready busy", 128'(bz4), 128'd0);
        chk("stray res_ready valid", 128'(rv4), 128'd0);

        // Reset in RUN at idx = 2
        sv4 = 1'b1; op4 = 1'b0;
        a4 = 128'h4444_4444_3333_3333_2222_2222_1111_1111; b4 = '0;
        @(posedge clk); #1;
        sv4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid-run busy", 128'(bz4), 128'd1);
        chk("mid-run partial", res4, 128'h2222_2222_1111_1111);
        #2 rst_n = 1'b0;
        #1;
        chk_reset4("mid-run reset");
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        run4(1'b0, 128'h3, 128'h4, lat);
        chk("post-reset latency", 128'(lat), 128'd4);
        chk("post-reset result", res4, 128'h7);
        release4();

        // WORDS = 1: latency 1, and reset while in RUN
        run1(1'b0, 32'h3, 32'h4, lat);
        chk("w1 latency", 128'(lat), 128'd1);
        chk("w1 result", 128'(res1), 128'h7);
        release1();
        run1(1'b0, 32'h7FFF_FFFF, 32'h1, lat);
        chk("w1 ovf result", 128'(res1), 128'h8000_0000);
        chk("w1 ovf overflow", 128'(ov1), 128'd1);
        chk("w1 ovf cout", 128'(co1), 128'd0);
        release1();
        sv1 = 1'b1; op1 = 1'b0; a1 = 32'hFFFF_FFFF; b1 = 32'h1;
        @(posedge clk); #1;
        sv1 = 1'b0;
        chk("w1 in RUN busy", 128'(bz1), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("w1 reset busy", 128'(bz1), 128'd0);
        chk("w1 reset valid", 128'(rv1), 128'd0);
        chk("w1 reset result", 128'(res1), 128'd0);
        chk("w1 reset start_ready", 128'(sr1), 128'd1);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        run1(1'b0, 32'hFFFF_FFFF, 32'h1, lat);
        chk("w1 post-reset latency", 128'(lat), 128'd1);
        chk("w1 post-reset result", 128'(res1), 128'h0);
        chk("w1 post-reset cout", 128'(co1), 128'd1);
        release1();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_addsub_ctrl.md
Name: mp_addsub_ctrl

Overview:
Multi-precision add/subtract sequencer. It reuses one 32-bit adder over WORDS consecutive cycles, chaining the carry word by word, to add or subtract operands of 32*WORDS bits. Requests use a valid/ready handshake and results are held until accepted. It sits between the ALU issue logic and the shared 32-bit adder datapath.

Parameters:
WORDS, 4, number of 32-bit words per operand (legal range 1..16); operand width is 32*WORDS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request valid
start_ready  output  1  controller can accept a request
op_sub  input  1  0 = a+b, 1 = a-b; sampled on accept
a  input  32*WORDS  operand A; sampled on accept
b  input  32*WORDS  operand B; sampled on accept
res_valid  output  1  result, cout and overflow are valid
res_ready  input  1  consumer accepts the result
result  output  32*WORDS  sum or difference
cout  output  1  final carry-out; for subtract, 1 = no borrow (a >= b unsigned)
overflow  output  1  signed two's-complement overflow of the full-width operation
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- During and after reset:
  - state = IDLE.
  - result, cout, overflow, res_valid, busy = 0.
  - Word index = 0, carry register = 0.
  - start_ready = 1, decoded combinationally from state == IDLE.
- State machine, three states:
  - IDLE: start_ready = 1. On start_valid && start_ready, latch:
    - a_reg = a.
    - b_reg = op_sub ? ~b : b.
    - carry = op_sub.
    - idx = 0.
    - result = 0.
    - Go to RUN.
  - RUN: each cycle the adder takes a_reg word idx, b_reg word idx and carry.
    - Sum goes to result word idx; carry takes the adder carry-out.
    - If idx == WORDS-1: cout takes the adder carry-out, overflow is set (rule below), and the state goes to DONE. Otherwise idx increments.
  - DONE: res_valid = 1.
    - result, cout and overflow stay stable until res_valid && res_ready.
    - On that handshake: go to IDLE, res_valid falls.
    - start_ready = 0, so start_valid is ignored.
- Latency: the request is accepted at edge N and res_valid is high from edge N+WORDS.
  - Minimum initiation interval is WORDS+2 cycles: IDLE, RUN×WORDS, DONE.
  - With WORDS = 1, RUN lasts exactly one cycle.
- Overflow rule, evaluated on the top word using the effective (inverted) B:
  - overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Arithmetic:
  - Pure modular 32*WORDS-bit arithmetic; no saturation.
  - Subtract is A + ~B + 1, with the +1 injected as the initial carry.
- Input timing: a, b and op_sub are don't-care outside the accept cycle. Internal registers isolate the operation from input changes.
- Reset mid-operation (RUN or DONE):
  - Aborts immediately; no partial result is ever presented.
  - All outputs return to their reset values.
  - The next request after reset completes correctly.
- Invalid inputs: res_ready with res_valid low has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - WORD_W = 32.
  - State encoding typedef: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - An idx width function computing max(1, clog2(WORDS)).
- Natural sub-module: one instance of the existing fulladder_32bit as the per-word adder.
- Word selection uses indexed part-selects on a_reg, b_reg and result.

Test Plan:
1. WORDS=4, add, a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=0x1 -> result=0x0000_0000_0000_0000_0000_0001_0000_0000, cout=0, overflow=0, res_valid exactly 4 cycles after accept.
2. Full ripple: a=all ones, b=0x1, add -> result=0, cout=1, overflow=0.
3. Subtract: a=0x5, b=0x7 -> result=0xFFFF_…_FFFE (all ones except bit 0 = 0, i.e. -2), cout=0 (borrow), overflow=0. Then a=0x7, b=0x5 -> result=0x2, cout=1.
4. Signed overflow:
   - add a=0x7FFF_…_FFFF, b=0x1 -> result=0x8000_…_0000, overflow=1, cout=0.
   - sub a=0x8000_…_0000, b=0x1 -> result=0x7FFF_…_FFFF, overflow=1.
5. Backpressure: hold res_ready=0 for 10 cycles with start_valid=1 and toggling a/b.
   - result, cout and overflow stay stable; start_ready=0; no new request is accepted.
   - After the res_ready pulse, state is IDLE next cycle and start_ready=1.
6. Reset in RUN at idx=2: assert rst_n=0 asynchronously.
   - All outputs 0, busy=0, start_ready=1.
   - After release, a fresh add of 0x3 + 0x4 returns 0x7.
   - Repeat the test with WORDS=1 (latency 1).
